// File: rtl/mem_responder.sv
// ============================================================================
// Module   : mem_responder
// Purpose  : Single-port 32-bit word memory that answers CPU load/store
//            requests after a programmable number of wait states. One access
//            is in flight at a time; requests outside IDLE are ignored.
// Revision : 1.0 - initial release
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, 2..1024)
//   WAIT_CYCLES  wait states inserted before each response (0..15)
//
// Ports
//   clock     in   1   rising-edge clock
//   reset_n   in   1   asynchronous active-low reset
//   addr      in  32   byte address (word index = addr[log2(DEPTH)+1:2])
//   wdata     in  32   store data
//   memRead   in   1   load request
//   memWrite  in   1   store request (wins when both requests are high)
//   rdata     out 32   registered load data, held until the next load
//   ready     out  1   one-cycle completion strobe
//   busy      out  1   high whenever the FSM is not IDLE
//   err       out  1   completed access was rejected (valid with ready)
//
// Configuration macro
//   MEM_ALIGN_CHECK_EN  when defined, a request with addr[1:0] != 0 completes
//                       with ready=1, err=1, no array write and rdata held.
//                       When undefined, err is tied low.
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        memRead,
  input  logic        memWrite,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int         IDX_W  = $clog2(DEPTH);
  localparam logic [3:0] C_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic [IDX_W-1:0] req_idx;
  logic [31:0]      req_wdata;
  logic             req_is_wr;

  logic [31:0]      mem [DEPTH];

  logic             req;
  logic             enter_resp;
  logic [IDX_W-1:0] access_idx;
  logic [31:0]      access_wdata;
  logic             access_is_wr;
  logic             access_bad;

  // Bits of addr that never select a word; gathered here so their absence
  // from the datapath is explicit.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr[31:IDX_W+2], addr[1:0]};

  assign req  = memRead | memWrite;
  assign busy = (state != IDLE);

  // The array/rdata update happens on the edge that enters RESP. With zero
  // wait states that edge is the accept edge itself, so the live request
  // inputs are used; otherwise the values captured at accept are used.
  assign enter_resp = ((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                      ((state == WAIT) && (cnt == 4'd1));

  assign access_idx   = (state == IDLE) ? addr[IDX_W+1:2] : req_idx;
  assign access_wdata = (state == IDLE) ? wdata           : req_wdata;
  assign access_is_wr = (state == IDLE) ? memWrite        : req_is_wr;

`ifdef MEM_ALIGN_CHECK_EN
  logic req_bad;

  assign access_bad = (state == IDLE) ? (addr[1:0] != 2'b00) : req_bad;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_bad <= 1'b0;
      err     <= 1'b0;
    end else begin
      if ((state == IDLE) && req) begin
        req_bad <= (addr[1:0] != 2'b00);
      end
      // err only ever rises together with ready.
      err <= enter_resp & access_bad;
    end
  end
`else
  assign access_bad = 1'b0;
  assign err        = 1'b0;
`endif

  // Main FSM with registered ready/rdata.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      ready     <= 1'b0;
      rdata     <= 32'h0000_0000;
      req_idx   <= '0;
      req_wdata <= 32'h0000_0000;
      req_is_wr <= 1'b0;
    end else begin
      ready <= 1'b0;

      case (state)
        IDLE: begin
          if (req) begin
            req_idx   <= addr[IDX_W+1:2];
            req_wdata <= wdata;
            req_is_wr <= memWrite;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= C_WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (enter_resp) begin
        ready <= 1'b1;
        if (!access_is_wr && !access_bad) begin
          rdata <= mem[access_idx];
        end
      end
    end
  end

  // Array storage is deliberately not reset. A reset while an access is
  // pending returns the FSM to IDLE, so enter_resp never fires for it.
  always_ff @(posedge clock) begin
    if (enter_resp && access_is_wr && !access_bad) begin
      mem[access_idx] <= access_wdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none

module tb_mem_responder;

  logic        clock;
  logic        reset_n;

  logic [31:0] addr, wdata, rdata;
  logic        memRead, memWrite, ready, busy, err;

  logic [31:0] addr2, wdata2, rdata2;
  logic        memRead2, memWrite2, ready2, busy2, err2;

  int total;
  int bad;

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .addr    (addr),
    .wdata   (wdata),
    .memRead (memRead),
    .memWrite(memWrite),
    .rdata   (rdata),
    .ready   (ready),
    .busy    (busy),
    .err     (err)
  );

  mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dut0 (
    .clock   (clock),
    .reset_n (reset_n),
    .addr    (addr2),
    .wdata   (wdata2),
    .memRead (memRead2),
    .memWrite(memWrite2),
    .rdata   (rdata2),
    .ready   (ready2),
    .busy    (busy2),
    .err     (err2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=2 instance. lat counts rising edges from
  // the accept edge (inclusive) to the edge that raised ready; bcnt counts
  // cycles with busy high.
  task automatic access(input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output int bcnt,
                        output logic [31:0] rd, output logic er);
    @(negedge clock);
    memWrite = w; memRead = r; addr = a; wdata = d;
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    memWrite = 1'b0; memRead = 1'b0;
    bcnt = busy ? 1 : 0;
    while (!ready && lat < 20) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (busy) bcnt++;
    end
    rd = rdata;
    er = err;
  endtask

  int          lat, bcnt, rdy_cnt;
  logic [31:0] rd;
  logic        er;

  initial begin
    total = 0; bad = 0;
    reset_n = 1'b0;
    addr = '0; wdata = '0; memRead = 1'b0; memWrite = 1'b0;
    addr2 = '0; wdata2 = '0; memRead2 = 1'b0; memWrite2 = 1'b0;

    // Reset state
    #2;
    chk("rst_ready", ready, 0);
    chk("rst_busy",  busy,  0);
    chk("rst_err",   err,   0);
    chk("rst_rdata", rdata, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    // Write then read
    access(1, 0, 32'h10, 32'hDEADBEEF, lat, bcnt, rd, er);
    chk("wr_latency", lat, 3);
    chk("wr_busy_cycles", bcnt, 3);
    chk("wr_err", er, 0);
    chk("wr_rdata_held", rd, 32'h0);
    @(negedge clock);
    chk("after_ready_low", ready, 0);
    chk("after_busy_low", busy, 0);
    access(0, 1, 32'h10, 32'h0, lat, bcnt, rd, er);
    chk("rd_latency", lat, 3);
    chk("rd_data", rd, 32'hDEADBEEF);

    // Wrap-around: 0x100 aliases word 0
    access(1, 0, 32'h100, 32'h12345678, lat, bcnt, rd, er);
    access(0, 1, 32'h000, 32'h0, lat, bcnt, rd, er);
    chk("wrap_rd", rd, 32'h12345678);

    // Simultaneous read+write is a write
    access(1, 1, 32'h8, 32'hA5A5A5A5, lat, bcnt, rd, er);
    chk("both_rdata_held", rd, 32'h12345678);
    access(0, 1, 32'h8, 32'h0, lat, bcnt, rd, er);
    chk("both_array", rd, 32'hA5A5A5A5);

    // Request pulsed while busy is ignored
    @(negedge clock);
    memRead = 1'b1; addr = 32'h10;
    @(posedge clock);
    @(negedge clock);
    memRead = 1'b0; memWrite = 1'b1; wdata = 32'h0;
    rdy_cnt = ready ? 1 : 0;
    @(negedge clock);
    memWrite = 1'b0;
    if (ready) rdy_cnt++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (ready) rdy_cnt++;
    end
    chk("busy_pulse_readies", rdy_cnt, 1);
    chk("busy_pulse_rdata", rdata, 32'hDEADBEEF);
    access(0, 1, 32'h10, 32'h0, lat, bcnt, rd, er);
    chk("busy_pulse_no_write", rd, 32'hDEADBEEF);

    // Reset during WAIT abandons the write
    access(1, 0, 32'h4, 32'h11111111, lat, bcnt, rd, er);
    @(negedge clock);
    memWrite = 1'b1; addr = 32'h4; wdata = 32'hFFFFFFFF;
    @(posedge clock);
    @(negedge clock);
    memWrite = 1'b0;
    chk("pre_rst_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", ready, 0);
    chk("midrst_rdata", rdata, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (ready) rdy_cnt++;
    end
    chk("midrst_no_ready", rdy_cnt, 0);
    access(0, 1, 32'h4, 32'h0, lat, bcnt, rd, er);
    chk("midrst_array_kept", rd, 32'h11111111);
    chk("post_rst_latency", lat, 3);

    // Misaligned write to 0x6
    access(1, 0, 32'h6, 32'hCAFEF00D, lat, bcnt, rd, er);
    chk("mis_latency", lat, 3);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_err", er, 1);
    access(0, 1, 32'h4, 32'h0, lat, bcnt, rd, er);
    chk("mis_array", rd, 32'h11111111);
`else
    chk("mis_err", er, 0);
    access(0, 1, 32'h4, 32'h0, lat, bcnt, rd, er);
    chk("mis_array", rd, 32'hCAFEF00D);
`endif
    @(negedge clock);
    chk("err_idle_low", err, 0);

    // WAIT_CYCLES=0: write, then hold memRead for back-to-back reads
    @(negedge clock);
    memWrite2 = 1'b1; addr2 = 32'h0; wdata2 = 32'h0BADF00D;
    @(negedge clock);
    memWrite2 = 1'b0;
    chk("w0_wr_ready", ready2, 1);
    chk("w0_wr_busy", busy2, 1);
    @(negedge clock);
    chk("w0_idle_busy", busy2, 0);
    memRead2 = 1'b1;
    @(negedge clock);
    chk("w0_b1_busy", busy2, 1);
    chk("w0_b1_ready", ready2, 1);
    chk("w0_b1_rdata", rdata2, 32'h0BADF00D);
    @(negedge clock);
    chk("w0_b2_busy", busy2, 0);
    chk("w0_b2_ready", ready2, 0);
    @(negedge clock);
    chk("w0_b3_busy", busy2, 1);
    chk("w0_b3_ready", ready2, 1);
    @(negedge clock);
    chk("w0_b4_busy", busy2, 0);
    memRead2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, giving the number of 32-bit words in the array (power of two, 2..1024).
REQ-002 The module SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted before each response (0..15).
REQ-003 The module SHALL have port clock, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port addr, input, 32 bits: byte address from the CPU.
REQ-006 The module SHALL have port wdata, input, 32 bits: store data.
REQ-007 The module SHALL have port memRead, input, 1 bit: load request.
REQ-008 The module SHALL have port memWrite, input, 1 bit: store request.
REQ-009 The module SHALL have port rdata, output, 32 bits: load data, registered.
REQ-010 The module SHALL have port ready, output, 1 bit: one-cycle completion strobe.
REQ-011 The module SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-012 The module SHALL have port err, output, 1 bit: the completed access was rejected.

Function
REQ-013 The FSM SHALL have exactly the states IDLE, WAIT and RESP.
REQ-014 In IDLE, a rising edge with memRead or memWrite high SHALL accept the request and capture addr, wdata and the operation.
- The next state is WAIT with counter = WAIT_CYCLES, or RESP when WAIT_CYCLES = 0.
REQ-015 If memRead and memWrite are both high, the block SHALL treat the request as a write and ignore the read.
REQ-016 In WAIT, the counter SHALL decrement each edge; the edge on which it reaches 0 SHALL move the FSM to RESP.
REQ-017 Request inputs SHALL be ignored outside IDLE; there is no queueing, and a request held high is re-accepted on the first IDLE edge.
REQ-018 The accept-to-ready latency SHALL be exactly WAIT_CYCLES+1 rising edges; ready is high for exactly one cycle in RESP, after which the FSM returns to IDLE.
REQ-019 The word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH.
REQ-020 A write SHALL update array[index] on the edge that enters RESP.
REQ-021 A read SHALL load rdata from array[index] on the edge that enters RESP.
REQ-022 rdata SHALL hold its value until the next completed read and SHALL be unchanged by writes.
REQ-023 A read from an index written by the immediately preceding request SHALL return the new data.
REQ-024 err SHALL be valid only while ready is high and SHALL be 0 at all other times.

Reset
REQ-025 Asserting reset_n low SHALL immediately force: state IDLE, ready 0, busy 0, err 0, rdata 0x00000000, counter 0.
REQ-026 Reset during WAIT SHALL abandon the pending access; a pending write SHALL NOT modify the array.
REQ-027 Array contents SHALL NOT be cleared by reset.
REQ-028 After reset_n deasserts, the first rising edge SHALL be able to accept a request.

Configuration
REQ-029 With macro MEM_ALIGN_CHECK_EN defined, a request with addr[1:0] != 0 SHALL complete with normal latency and ready=1, err=1.
- On such a request, no array write occurs and rdata is unchanged.
REQ-030 Without MEM_ALIGN_CHECK_EN defined, addr[1:0] SHALL be ignored, err SHALL be tied to 0, and no alignment logic is present.

Verification
REQ-031 Write then read, WAIT_CYCLES=2:
- Write addr 0x10, data 0xDEADBEEF; ready is high 3 edges after accept and busy is high for 3 cycles.
- Read addr 0x10; rdata = 0xDEADBEEF when ready is high.
REQ-032 Wrap-around, DEPTH=64: write 0x12345678 to addr 0x100, then read addr 0x000 -> rdata = 0x12345678.
REQ-033 Simultaneous and ignored requests:
- memRead=memWrite=1 with addr 0x8, wdata 0xA5A5A5A5 -> array[2] = 0xA5A5A5A5 and rdata is unchanged.
- A request pulsed for one cycle while busy -> no second ready.
REQ-034 Reset mid-operation: write 0xFFFFFFFF to addr 0x4, pull reset_n low during WAIT -> busy=0 immediately, no ready, and a later read of 0x4 returns the prior contents.
REQ-035 With MEM_ALIGN_CHECK_EN defined: write to addr 0x6 -> ready=1, err=1, array unchanged. Without the macro, the same write -> err=0 and array[1] is written.
REQ-036 WAIT_CYCLES=0 back-to-back: memRead held high for addr 0x0 -> ready on alternate cycles, with busy toggling 1,0,1,0.
